sram_port_arbiter: RTL and testbench

//  Shares one single-ported SRAM-like memory between the CPU instruction-fetch and data-access ports.

---
 rtl/sram_port_arbiter_pkg.sv | 19 +
 rtl/sram_port_arbiter_arb_prio_sel.sv | 24 ++
 rtl/sram_port_arbiter.sv | 122 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the single-port SRAM arbiter: FSM states, winner encoding
// and the read write-enable constant.
package sram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusyI = 2'd1,
        StBusyD = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        WinNone = 2'd0,
        WinInst = 2'd1,
        WinData = 2'd2
    } arb_winner_e;

    localparam logic [3:0] WenRead = 4'b0000;

endpackage

// File: rtl/sram_port_arbiter_arb_prio_sel.sv
// Combinational winner select: data wins ties unless the fetch side has been
// starved for a full streak.
module arb_prio_sel
    import sram_port_arbiter_pkg::*;
(
    input  logic        inst_req,
    input  logic        data_req,
    input  logic        streak_full,
    input  logic        free,
    output arb_winner_e winner
);

    always_comb begin
        winner = WinNone;
        if (free) begin
            if (data_req && !(inst_req && streak_full)) begin
                winner = WinData;
            end else if (inst_req) begin
                winner = WinInst;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access,
// one transaction outstanding, with a fixed RD_LAT completion delay.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned RD_LAT          = 1,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_en,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned    StreakW   = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [2:0]     LatInit   = 3'(RD_LAT);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_DATA_STREAK);

    arb_state_e         state;
    logic [2:0]         lat_cnt;
    logic [StreakW-1:0] streak_cnt;
    logic [31:0]        inst_rdata_q;
    logic [31:0]        data_rdata_q;

    logic        done;
    logic        free;
    logic        inst_done;
    logic        data_done;
    logic        grant_i;
    logic        grant_d;
    arb_winner_e winner;

    // Completion cycle doubles as an issue slot so back-to-back accesses need no bubble.
    assign done      = resetn && (state != StIdle) && (lat_cnt == 3'd1);
    assign free      = resetn && ((state == StIdle) || (lat_cnt == 3'd1));
    assign inst_done = done && (state == StBusyI);
    assign data_done = done && (state == StBusyD);

    arb_prio_sel u_prio_sel (
        .inst_req    (inst_req),
        .data_req    (data_req),
        .streak_full (streak_cnt == StreakMax),
        .free        (free),
        .winner      (winner)
    );

    assign grant_i = (winner == WinInst);
    assign grant_d = (winner == WinData);

    always_comb begin
        inst_addr_ok = grant_i;
        data_addr_ok = grant_d;
        mem_en       = grant_i || grant_d;
        mem_wen      = grant_d ? data_wen : WenRead;
        mem_addr     = grant_i ? inst_addr : (grant_d ? data_addr : 32'd0);
        mem_wdata    = grant_d ? data_wdata : 32'd0;
        inst_data_ok = inst_done;
        data_data_ok = data_done;
        inst_rdata   = inst_done ? mem_rdata : inst_rdata_q;
        data_rdata   = data_done ? mem_rdata : data_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= StIdle;
            lat_cnt      <= 3'd0;
            streak_cnt   <= '0;
            inst_rdata_q <= 32'd0;
            data_rdata_q <= 32'd0;
        end else begin
            if (inst_done) begin
                inst_rdata_q <= mem_rdata;
            end
            if (data_done) begin
                data_rdata_q <= mem_rdata;
            end

            case (winner)
                WinInst: begin
                    state   <= StBusyI;
                    lat_cnt <= LatInit;
                end
                WinData: begin
                    state   <= StBusyD;
                    lat_cnt <= LatInit;
                end
                default: begin
                    if (state != StIdle) begin
                        if (lat_cnt == 3'd1) begin
                            state   <= StIdle;
                            lat_cnt <= 3'd0;
                        end else begin
                            lat_cnt <= lat_cnt - 3'd1;
                        end
                    end
                end
            endcase

            if (!inst_req || grant_i) begin
                streak_cnt <= '0;
            end else if (grant_d && (streak_cnt != StreakMax)) begin
                streak_cnt <= streak_cnt + StreakW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed and random traffic against a
// transaction-level reference model, plus a RD_LAT=3 instance for mid-op reset.
module tb_sram_port_arbiter;

    localparam int MaxStreak = 4;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        r3_resetn;
    logic        r3_inst_req;
    logic [31:0] r3_inst_addr;
    logic        r3_inst_addr_ok;
    logic        r3_inst_data_ok;
    logic [31:0] r3_inst_rdata;
    logic        r3_data_req;
    logic [31:0] r3_data_addr;
    logic        r3_data_addr_ok;
    logic        r3_data_data_ok;
    logic [31:0] r3_data_rdata;
    logic        r3_mem_en;
    logic [3:0]  r3_mem_wen;
    logic [31:0] r3_mem_addr;
    logic [31:0] r3_mem_wdata;

    int checks = 0;
    int errors = 0;

    sram_port_arbiter #(.RD_LAT(1), .MAX_DATA_STREAK(MaxStreak)) u_dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wen     (data_wen),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_en       (mem_en),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    sram_port_arbiter #(.RD_LAT(3), .MAX_DATA_STREAK(MaxStreak)) u_dut_lat3 (
        .clk          (clk),
        .resetn       (r3_resetn),
        .inst_req     (r3_inst_req),
        .inst_addr    (r3_inst_addr),
        .inst_addr_ok (r3_inst_addr_ok),
        .inst_data_ok (r3_inst_data_ok),
        .inst_rdata   (r3_inst_rdata),
        .data_req     (r3_data_req),
        .data_wen     (4'b0000),
        .data_addr    (r3_data_addr),
        .data_wdata   (32'd0),
        .data_addr_ok (r3_data_addr_ok),
        .data_data_ok (r3_data_data_ok),
        .data_rdata   (r3_data_rdata),
        .mem_en       (r3_mem_en),
        .mem_wen      (r3_mem_wen),
        .mem_addr     (r3_mem_addr),
        .mem_wdata    (r3_mem_wdata),
        .mem_rdata    (32'hCAFE_F00D)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] init_word(input int i);
        return 32'h5A00_0000 ^ (32'(i) * 32'h0011_0103);
    endfunction

    // One-cycle-latency memory: returns the word as it was before any write.
    logic [31:0] mem [16];
    logic [31:0] rd_q;
    always @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
            rd_q <= 32'd0;
        end else if (mem_en) begin
            rd_q <= mem[mem_addr[5:2]];
            for (int b = 0; b < 4; b++)
                if (mem_wen[b]) mem[mem_addr[5:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
    end
    assign mem_rdata = rd_q;

    // Reference model: cycles left on the open transaction, its owner, its result.
    int          rem = 0;
    bit          own_d = 1'b0;
    int          streak = 0;
    logic [31:0] pend_val = 32'd0;
    logic [31:0] exp_ir = 32'd0;
    logic [31:0] exp_dr = 32'd0;
    logic [31:0] ref_mem [16];
    bit          last_gi;
    bit          last_gd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rn, input logic ir, input logic [31:0] ia, input logic dr,
                        input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dwd);
        bit done, free, gi, gd;
        logic [31:0] e_addr;
        @(posedge clk);
        #1;
        resetn = rn; inst_req = ir; inst_addr = ia;
        data_req = dr; data_wen = dw; data_addr = da; data_wdata = dwd;
        #2;
        if (!rn) begin
            chk("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
            chk("rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
            chk("rst_inst_data_ok", 32'(inst_data_ok), 32'd0);
            chk("rst_data_data_ok", 32'(data_data_ok), 32'd0);
            chk("rst_mem_en", 32'(mem_en), 32'd0);
            chk("rst_mem_wen", 32'(mem_wen), 32'd0);
            chk("rst_inst_rdata", inst_rdata, exp_ir);
            chk("rst_data_rdata", data_rdata, exp_dr);
            rem = 0; streak = 0; exp_ir = 32'd0; exp_dr = 32'd0;
            for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
            last_gi = 1'b0; last_gd = 1'b0;
        end else begin
            done = (rem == 1);
            free = (rem == 0) || done;
            gi = free && ir && (!dr || streak == MaxStreak);
            gd = free && dr && !gi;
            e_addr = gi ? ia : (gd ? da : 32'd0);
            chk("inst_addr_ok", 32'(inst_addr_ok), 32'(gi));
            chk("data_addr_ok", 32'(data_addr_ok), 32'(gd));
            chk("mem_en", 32'(mem_en), 32'(gi | gd));
            chk("mem_wen", 32'(mem_wen), gd ? 32'(dw) : 32'd0);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, gd ? dwd : 32'd0);
            chk("inst_data_ok", 32'(inst_data_ok), 32'(done && !own_d));
            chk("data_data_ok", 32'(data_data_ok), 32'(done && own_d));
            if (done) begin
                if (own_d) exp_dr = pend_val;
                else exp_ir = pend_val;
            end
            chk("inst_rdata", inst_rdata, exp_ir);
            chk("data_rdata", data_rdata, exp_dr);
            if (gi || gd) begin
                rem = 1;
                own_d = gd;
                pend_val = ref_mem[e_addr[5:2]];
                if (gd)
                    for (int b = 0; b < 4; b++)
                        if (dw[b]) ref_mem[e_addr[5:2]][b*8 +: 8] = dwd[b*8 +: 8];
            end else if (rem > 0) begin
                rem--;
            end
            if (!ir || gi) streak = 0;
            else if (gd && streak < MaxStreak) streak++;
            last_gi = gi; last_gd = gd;
        end
    endtask

    task automatic step3(input logic rn, input logic ir, input logic [31:0] ia, input logic dr,
                         input logic [31:0] da);
        @(posedge clk);
        #1;
        r3_resetn = rn; r3_inst_req = ir; r3_inst_addr = ia;
        r3_data_req = dr; r3_data_addr = da;
        #2;
    endtask

    initial begin
        bit exp_seq [8];
        resetn = 1'b0; inst_req = 1'b0; inst_addr = 32'd0; data_req = 1'b0;
        data_wen = 4'd0; data_addr = 32'd0; data_wdata = 32'd0;
        r3_resetn = 1'b0; r3_inst_req = 1'b0; r3_inst_addr = 32'd0;
        r3_data_req = 1'b0; r3_data_addr = 32'd0;

        // Reset held with both requests pending; first grant after release is data.
        step(1'b0, 1'b1, 32'hBFC0_0004, 1'b1, 4'd0, 32'h8000_0008, 32'd0);
        step(1'b0, 1'b1, 32'hBFC0_0004, 1'b1, 4'd0, 32'h8000_0008, 32'd0);
        step(1'b1, 1'b1, 32'hBFC0_0004, 1'b1, 4'd0, 32'h8000_0008, 32'd0);
        chk("first_grant_data", 32'(data_addr_ok), 32'd1);
        step(1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);

        // Single fetch.
        step(1'b1, 1'b1, 32'hBFC0_0000, 1'b0, 4'd0, 32'd0, 32'd0);
        chk("fetch_addr", mem_addr, 32'hBFC0_0000);
        step(1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        chk("fetch_rdata", inst_rdata, init_word(0));

        // Collision: data first, inst issued in the data completion cycle.
        step(1'b1, 1'b1, 32'hBFC0_0004, 1'b1, 4'd0, 32'h8000_0010, 32'd0);
        step(1'b1, 1'b1, 32'hBFC0_0004, 1'b0, 4'd0, 32'd0, 32'd0);
        chk("coll_data_ok_and_inst_grant", 32'({data_data_ok, inst_addr_ok}), 32'd3);
        step(1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);

        // Partial store.
        step(1'b1, 1'b0, 32'd0, 1'b1, 4'b0011, 32'h8000_0020, 32'h1234_5678);
        step(1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b1, 4'd0, 32'h8000_0020, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        chk("store_readback", data_rdata, (init_word(8) & 32'hFFFF_0000) | 32'h0000_5678);

        // Starvation guard: both held for 8 cycles.
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int c = 0; c < 8; c++) begin
            step(1'b1, 1'b1, 32'hBFC0_0000 | 32'(c << 2), 1'b1, 4'd0,
                 32'h8000_0000 | 32'(c << 2), 32'd0);
            chk("starve_grant_is_data", 32'(data_addr_ok), 32'(exp_seq[c]));
            chk("starve_model_grant", 32'(last_gd), 32'(exp_seq[c]));
        end

        // Random traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            logic [3:0] w;
            w = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            step(($urandom_range(0, 39) != 0), 1'($urandom), 32'hBFC0_0000 | (32'($urandom) & 32'h3C),
                 1'($urandom), w, 32'h8000_0000 | (32'($urandom) & 32'h3C), $urandom);
        end

        // RD_LAT=3 instance: reset one cycle after a data grant kills the transaction.
        step3(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        step3(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("r3_rst_mem_en", 32'(r3_mem_en), 32'd0);
        step3(1'b1, 1'b0, 32'd0, 1'b1, 32'h8000_0040);
        chk("r3_data_grant", 32'(r3_data_addr_ok), 32'd1);
        step3(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("r3_rst_data_ok", 32'(r3_data_data_ok), 32'd0);
        for (int c = 0; c < 4; c++) begin
            step3(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
            chk("r3_no_data_ok", 32'({r3_data_data_ok, r3_inst_data_ok}), 32'd0);
            chk("r3_data_rdata_zero", r3_data_rdata, 32'd0);
        end
        step3(1'b1, 1'b1, 32'hBFC0_0008, 1'b0, 32'd0);
        chk("r3_idle_grant", 32'(r3_inst_addr_ok), 32'd1);
        chk("r3_idle_addr", r3_mem_addr, 32'hBFC0_0008);
        step3(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("r3_lat_t1", 32'(r3_inst_data_ok), 32'd0);
        step3(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("r3_lat_t2", 32'(r3_inst_data_ok), 32'd0);
        step3(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("r3_lat_t3", 32'(r3_inst_data_ok), 32'd1);
        chk("r3_inst_rdata", r3_inst_rdata, 32'hCAFE_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
